// File: rtl/fifo_wr_frontend_if.sv
// Write-side stream/FIFO bundle for fifo_wr_frontend.
// slave = the front end itself, master = the surrounding logic that drives it.
interface fifo_wr_frontend_if #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
);
  logic                 s_valid;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_ready;
  logic                 winc;
  logic [DATA_SIZE-1:0] wdata;
  logic                 wfull;
  logic [ADDR_SIZE:0]   wptr;
  logic [ADDR_SIZE:0]   wq2_rptr;
  logic [ADDR_SIZE:0]   wlevel;
  logic                 walmost_full;

  modport slave (
    input  s_valid, s_data, wfull, wptr, wq2_rptr,
    output s_ready, winc, wdata, wlevel, walmost_full
  );

  modport master (
    output s_valid, s_data, wfull, wptr, wq2_rptr,
    input  s_ready, winc, wdata, wlevel, walmost_full
  );
endinterface

// File: rtl/fifo_wr_frontend.sv
// Async FIFO write front end: 2-entry skid buffer feeding winc/wdata, plus Gray-pointer fill level.
// Define FIFO_WR_LEVEL_EN to build the wlevel/walmost_full decode; otherwise both are tied to 0.
module fifo_wr_frontend #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  fifo_wr_frontend_if.slave     bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [ADDR_SIZE:0] AFULL_LVL = (ADDR_SIZE + 1)'(AFULL_THRESH);

  state_t               state_r;
  state_t               next_state_s;
  logic                 s_ready_r;
  logic                 accept_s;
  logic                 winc_s;
  logic [DATA_SIZE-1:0] head_r;
  logic [DATA_SIZE-1:0] tail_r;

  assign accept_s    = bus.s_valid & s_ready_r;
  assign bus.s_ready = s_ready_r;
  assign bus.winc    = winc_s;
  assign bus.wdata   = head_r;

  // State register; s_ready is registered from next state so wfull never reaches it combinationally
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r   <= EMPTY;
      s_ready_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      s_ready_r <= (next_state_s != TWO);
    end
  end

  // Next-state logic for the entry count
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) next_state_s = ONE;
        else          next_state_s = EMPTY;
      end
      ONE: begin
        if (accept_s && !winc_s)      next_state_s = TWO;
        else if (!accept_s && winc_s) next_state_s = EMPTY;
        else                          next_state_s = ONE;
      end
      TWO: begin
        if (winc_s) next_state_s = ONE;
        else        next_state_s = TWO;
      end
      default: next_state_s = EMPTY;
    endcase
  end

  // Output logic: write whenever something is buffered and the FIFO has room
  always_comb begin
    winc_s = 1'b0;
    if (state_r != EMPTY) winc_s = ~bus.wfull;
    else                  winc_s = 1'b0;
  end

  // Skid storage: head is the oldest word, tail only holds the second entry
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      head_r <= {DATA_SIZE{1'b0}};
      tail_r <= {DATA_SIZE{1'b0}};
    end else begin
      case (state_r)
        EMPTY: if (accept_s) head_r <= bus.s_data;
        ONE: begin
          if (accept_s) begin
            if (winc_s) head_r <= bus.s_data;
            else        tail_r <= bus.s_data;
          end
        end
        TWO: if (winc_s) head_r <= tail_r;
        default: head_r <= head_r;
      endcase
    end
  end

`ifdef FIFO_WR_LEVEL_EN
  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [ADDR_SIZE:0] level_s;
  logic [ADDR_SIZE:0] wlevel_r;
  logic               walmost_full_r;

  // Modular subtraction over ADDR_SIZE+1 bits stays correct across pointer wrap
  assign level_s = gray2bin(bus.wptr) - gray2bin(bus.wq2_rptr);

  // Fill level and almost-full flag, one wclk behind the pointers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_r       <= {(ADDR_SIZE + 1){1'b0}};
      walmost_full_r <= 1'b0;
    end else begin
      wlevel_r       <= level_s;
      walmost_full_r <= (level_s >= AFULL_LVL);
    end
  end

  assign bus.wlevel       = wlevel_r;
  assign bus.walmost_full = walmost_full_r;
`else
  logic unused_level_s;
  assign unused_level_s   = ^{bus.wptr, bus.wq2_rptr, AFULL_LVL};
  assign bus.wlevel       = {(ADDR_SIZE + 1){1'b0}};
  assign bus.walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Directed bench for fifo_wr_frontend: vector table for streaming/backpressure/level, plus reset-in-TWO sequence.
module tb_fifo_wr_frontend;

  logic wclk;
  logic wrst_n;
  int   errors;
  int   checks;

`ifdef FIFO_WR_LEVEL_EN
  localparam bit LEVEL_ON = 1'b1;
`else
  localparam bit LEVEL_ON = 1'b0;
`endif

  fifo_wr_frontend_if #(.DATA_SIZE(8), .ADDR_SIZE(4)) bus ();

  fifo_wr_frontend #(
    .DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_THRESH(12)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Expected outputs are those seen with these inputs applied, before the next edge
  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       f;
    logic [4:0] wp;
    logic [4:0] rp;
    logic       rdy;
    logic       winc;
    logic [7:0] wdata;
    logic [4:0] lvl;
    logic       af;
  } vec_t;

  vec_t vecs [0:17];

  function automatic vec_t mk(logic v, logic [7:0] d, logic f, logic [4:0] wp, logic [4:0] rp,
                              logic rdy, logic winc, logic [7:0] wdata, logic [4:0] lvl, logic af);
    vec_t r;
    r.v = v; r.d = d; r.f = f; r.wp = wp; r.rp = rp;
    r.rdy = rdy; r.winc = winc; r.wdata = wdata; r.lvl = lvl; r.af = af;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic f,
                       input logic [4:0] wp, input logic [4:0] rp);
    bus.s_valid  = v;
    bus.s_data   = d;
    bus.wfull    = f;
    bus.wptr     = wp;
    bus.wq2_rptr = rp;
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic winc, input logic [7:0] wdata,
                         input logic [4:0] lvl, input logic af);
    chk({tag, ".s_ready"}, 32'(bus.s_ready), 32'(rdy));
    chk({tag, ".winc"}, 32'(bus.winc), 32'(winc));
    chk({tag, ".wdata"}, 32'(bus.wdata), 32'(wdata));
    chk({tag, ".wlevel"}, 32'(bus.wlevel), LEVEL_ON ? 32'(lvl) : 32'd0);
    chk({tag, ".walmost_full"}, 32'(bus.walmost_full), LEVEL_ON ? 32'(af) : 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    wrst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 5'h00, 5'h00);

    //              v     d      f     wp     rp     rdy   winc  wdata  lvl     af
    vecs[0]  = mk(1'b1, 8'h11, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 8'h00, 5'd0,  1'b0);
    vecs[1]  = mk(1'b1, 8'h11, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0);
    vecs[2]  = mk(1'b1, 8'h22, 1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 8'h11, 5'd0,  1'b0);
    vecs[3]  = mk(1'b1, 8'h33, 1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 8'h22, 5'd0,  1'b0);
    vecs[4]  = mk(1'b0, 8'h00, 1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 8'h33, 5'd0,  1'b0);
    vecs[5]  = mk(1'b1, 8'hA0, 1'b1, 5'h00, 5'h00, 1'b1, 1'b0, 8'h33, 5'd0,  1'b0);
    vecs[6]  = mk(1'b1, 8'hA1, 1'b1, 5'h00, 5'h00, 1'b1, 1'b0, 8'hA0, 5'd0,  1'b0);
    vecs[7]  = mk(1'b1, 8'hA2, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0, 8'hA0, 5'd0,  1'b0);
    vecs[8]  = mk(1'b1, 8'hA2, 1'b0, 5'h00, 5'h00, 1'b0, 1'b1, 8'hA0, 5'd0,  1'b0);
    vecs[9]  = mk(1'b1, 8'hA2, 1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 8'hA1, 5'd0,  1'b0);
    vecs[10] = mk(1'b0, 8'h00, 1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 8'hA2, 5'd0,  1'b0);
    vecs[11] = mk(1'b0, 8'h00, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 8'hA2, 5'd0,  1'b0);
    vecs[12] = mk(1'b0, 8'h00, 1'b0, 5'h0A, 5'h00, 1'b1, 1'b0, 8'hA2, 5'd0,  1'b0);
    vecs[13] = mk(1'b0, 8'h00, 1'b0, 5'h0A, 5'h01, 1'b1, 1'b0, 8'hA2, 5'd12, 1'b1);
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 5'h02, 5'h11, 1'b1, 1'b0, 8'hA2, 5'd11, 1'b0);
    vecs[15] = mk(1'b0, 8'h00, 1'b0, 5'h18, 5'h00, 1'b1, 1'b0, 8'hA2, 5'd5,  1'b0);
    vecs[16] = mk(1'b0, 8'h00, 1'b0, 5'h18, 5'h18, 1'b1, 1'b0, 8'hA2, 5'd16, 1'b1);
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 8'hA2, 5'd0,  1'b0);

    repeat (2) @(posedge wclk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);
    wrst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].wp, vecs[i].rp);
      #2;
      chk_all($sformatf("v%0d", i), vecs[i].rdy, vecs[i].winc, vecs[i].wdata, vecs[i].lvl, vecs[i].af);
      @(posedge wclk);
      #1;
    end

    // Fill to TWO under wfull with a level of 12, then reset asynchronously
    drive(1'b1, 8'hB0, 1'b1, 5'h0A, 5'h00);
    @(posedge wclk);
    #1;
    drive(1'b1, 8'hB1, 1'b1, 5'h0A, 5'h00);
    @(posedge wclk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 5'h0A, 5'h00);
    #2;
    chk_all("two_pre_rst", 1'b0, 1'b1, 8'hB0, 5'd12, 1'b1);
    wrst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);
    @(posedge wclk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 5'h00, 5'h00);
    wrst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("post_rst%0d.winc", k), 32'(bus.winc), 32'd0);
      @(posedge wclk);
      #1;
    end
    chk("post_rst.s_ready", 32'(bus.s_ready), 32'd1);
    drive(1'b1, 8'hC5, 1'b0, 5'h00, 5'h00);
    @(posedge wclk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 5'h00, 5'h00);
    #2;
    chk("fresh.winc", 32'(bus.winc), 32'd1);
    chk("fresh.wdata", 32'(bus.wdata), 32'hC5);
    @(posedge wclk);
    #1;
    chk("fresh_done.winc", 32'(bus.winc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_frontend.md
Name: fifo_wr_frontend

Overview:
- Write-side front end of the async FIFO; sits directly upstream of the write-pointer/full-flag stage.
- Accepts a valid/ready stream and holds it in a 2-entry skid buffer. Drives winc/wdata into the FIFO, using the registered wfull as backpressure.
- Decodes the Gray write pointer and the synchronised Gray read pointer into a registered fill level and an almost-full flag for upstream rate control.

Parameters:
- DATA_SIZE, 8, stream/FIFO data width
- ADDR_SIZE, 4, FIFO address width; depth = 2^ADDR_SIZE
- AFULL_THRESH, 12, fill level at or above which walmost_full asserts; legal range 1..2^ADDR_SIZE

Ports:
- wclk  in  1  write clock; single clock for the whole block
- wrst_n  in  1  asynchronous active-low reset
- s_valid  in  1  upstream data valid
- s_data  in  DATA_SIZE  upstream data
- s_ready  out  1  block can accept s_data this cycle
- winc  out  1  write strobe to FIFO
- wdata  out  DATA_SIZE  data written to FIFO memory when winc=1
- wfull  in  1  registered full flag from the write-pointer stage
- wptr  in  ADDR_SIZE+1  Gray write pointer from the write-pointer stage
- wq2_rptr  in  ADDR_SIZE+1  Gray read pointer, already synchronised into wclk
- wlevel  out  ADDR_SIZE+1  registered FIFO fill level, 0..2^ADDR_SIZE
- walmost_full  out  1  registered wlevel >= AFULL_THRESH

Behaviour:
- Reset (wrst_n=0, async): skid state EMPTY; s_ready=0 during reset and 1 from the first wclk edge after release; winc=0; wdata=0; wlevel=0; walmost_full=0. Buffer contents are discarded.
- Reset mid-operation: any buffered entries are lost. No winc is issued after reset asserts.
- Skid buffer: FSM with states EMPTY, ONE, TWO, tracking entry count. The entry head is the oldest entry.
- accept = s_valid & s_ready.
- winc = (state != EMPTY) & ~wfull. This is combinational from state and wfull. wdata = head entry.
- s_ready is a registered output, 1 whenever next state != TWO. There is no combinational path from wfull to s_ready.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & ~winc -> TWO; ~accept & winc -> EMPTY; otherwise stay.
  - TWO: winc -> ONE (no accept possible, since s_ready=0).
- Simultaneous accept and winc in state ONE: head is written to the FIFO, the new word becomes head, state stays ONE.
- Latency: a word accepted at edge N appears on wdata with winc=1 at edge N+1 at the earliest, if wfull=0. Throughput is 1 word/cycle sustained.
- Ordering is strict FIFO. No word is dropped or duplicated.
- wfull=1 holds winc=0. Data stays buffered and s_ready falls once state reaches TWO.
- Level computation:
  - Gray-to-binary decode of wptr and wq2_rptr: b[i] = XOR of g[ADDR_SIZE:i].
  - wlevel_next = (wbin - rbin) mod 2^(ADDR_SIZE+1). This is correct across pointer wrap.
  - wlevel and walmost_full are registered, one wclk behind their inputs.
  - wlevel excludes skid-buffer occupancy.
- When pointers are equal in all bits, wlevel=0. When the MSB and next bit differ and the rest match (full), wlevel=2^ADDR_SIZE.

Optional Feature:
- Macro FIFO_WR_LEVEL_EN.
- Defined: Gray decode, wlevel and walmost_full are implemented as above.
- Undefined: decode logic is omitted; wlevel is tied to 0 and walmost_full to 0. The wptr and wq2_rptr inputs remain as ports, unused. Skid buffer behaviour is identical in both builds.

Test Plan:
- Reset release, s_valid=1 with data 0x11,0x22,0x33 on consecutive cycles, wfull=0 -> winc=1 with wdata 0x11,0x22,0x33 starting one cycle after first accept; s_ready stays 1.
- wfull=1 held while s_valid=1 streams 0xA0,0xA1,0xA2 -> 0xA0 and 0xA1 are buffered, s_ready=0 after the second accept, winc=0; drop wfull -> 0xA0 then 0xA1 written, then 0xA2 accepted, order preserved.
- wptr=Gray(12)=0x0A, wq2_rptr=0 -> wlevel=12 and walmost_full=1 one cycle later; wq2_rptr=Gray(1)=0x01 -> wlevel=11, walmost_full=0.
- Wrap: wptr=Gray(3)=0x02, wq2_rptr=Gray(30)=0x11 -> wlevel=5. Full: wptr=Gray(16)=0x18, wq2_rptr=0 -> wlevel=16.
- Assert wrst_n=0 while state=TWO -> winc, wlevel and walmost_full go 0 immediately (async). After release, no stale words are written.
- Build without FIFO_WR_LEVEL_EN, repeat scenario 3 -> wlevel=0 and walmost_full=0 throughout; data path results match scenario 1.
